// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads the synchronous imem, presents {inst, pc, pred} to ID.
// Latency: 1 cycle fetch-to-present, 1 bubble on redirect. Optional static prediction: FETCH_STATIC_BP_EN.
// Backpressure: id_stall_i holds the presented word bit-stable (captured in hold_q) and stops fetching.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_en_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        id_stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o,
    output logic        pred_taken_o
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] cur_inst;
    logic [31:0] redir_pc;
    logic [31:0] next_pc;
    logic        pred_taken;
    logic        unused_redir_lsb;

    // Word being presented: live memory data in FETCH, captured copy in HOLD.
    assign cur_inst         = (state_q == HOLD) ? hold_q : imem_rdata_i;
    assign redir_pc         = {redirect_pc_i[31:2], 2'b00};
    assign unused_redir_lsb = ^redirect_pc_i[1:0];

`ifdef FETCH_STATIC_BP_EN
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic [31:0] target;
    logic        is_jal;
    logic        is_bwd_br;

    assign j_imm     = {{12{cur_inst[31]}}, cur_inst[19:12], cur_inst[20], cur_inst[30:21], 1'b0};
    assign b_imm     = {{20{cur_inst[31]}}, cur_inst[7], cur_inst[30:25], cur_inst[11:8], 1'b0};
    assign is_jal    = (cur_inst[6:2] == 5'b11011);
    assign is_bwd_br = (cur_inst[6:2] == 5'b11000) && cur_inst[31];
    assign target    = pc_q + (is_jal ? j_imm : b_imm);
    // Fetch addresses stay word-aligned even if an immediate has bit 1 set.
    assign next_pc    = (is_jal || is_bwd_br) ? {target[31:2], 2'b00} : pc_q + 32'd4;
    assign pred_taken = is_jal || is_bwd_br;
`else
    assign next_pc    = pc_q + 32'd4;
    assign pred_taken = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            hold_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        imem_en_o    = 1'b0;
        imem_addr_o  = pc_q;
        if_valid_o   = 1'b0;
        if_inst_o    = 32'd0;
        if_pc_o      = 32'd0;
        pred_taken_o = 1'b0;

        case (state_q)
            IDLE: begin
                imem_en_o   = 1'b1;
                imem_addr_o = RESET_PC;
                pc_d        = RESET_PC;
                state_d     = FETCH;
            end
            FETCH, HOLD: begin
                if_valid_o   = 1'b1;
                if_inst_o    = cur_inst;
                if_pc_o      = pc_q;
                pred_taken_o = pred_taken;
                if (id_stall_i) begin
                    hold_d  = cur_inst;
                    state_d = HOLD;
                end else begin
                    imem_en_o   = 1'b1;
                    imem_addr_o = next_pc;
                    pc_d        = next_pc;
                    state_d     = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect wins over stall and discards whatever is presented or in flight.
        if (redirect_i) begin
            if_valid_o   = 1'b0;
            pred_taken_o = 1'b0;
            imem_en_o    = 1'b1;
            imem_addr_o  = redir_pc;
            pc_d         = redir_pc;
            state_d      = FETCH;
        end

        // Outputs collapse to zero as soon as reset is asserted, not at the next edge.
        if (!rst_n) begin
            imem_en_o    = 1'b0;
            imem_addr_o  = 32'd0;
            if_valid_o   = 1'b0;
            if_inst_o    = 32'd0;
            if_pc_o      = 32'd0;
            pred_taken_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected instructions, a negedge monitor checks accepts.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h4000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        pred_taken;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   accepts = 0;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_en_o    (imem_en),
        .imem_addr_o  (imem_addr),
        .imem_rdata_i (imem_rdata),
        .id_stall_i   (id_stall),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .if_valid_o   (if_valid),
        .if_inst_o    (if_inst),
        .if_pc_o      (if_pc),
        .pred_taken_o (pred_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4000_0004) return 32'h0050_0093;
        if (a == 32'h4000_0010) return 32'hFE00_0EE3;
        return {a[26:2], 7'h13};
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic pred);
        exp_t e;
        e.pc   = pc;
        e.pred = pred;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},    {31'd0, imem_en},    32'd0);
        chk({tag, "_addr"},  imem_addr,           32'd0);
        chk({tag, "_valid"}, {31'd0, if_valid},   32'd0);
        chk({tag, "_inst"},  if_inst,             32'd0);
        chk({tag, "_pc"},    if_pc,               32'd0);
        chk({tag, "_pred"},  {31'd0, pred_taken}, 32'd0);
    endtask

    // Monitor: every accepted instruction must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && if_valid && !id_stall && !redirect) begin
            accepts++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_empty: accepted pc 0x%08h with nothing expected", if_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_pc",   if_pc,               e.pc);
                chk("mon_inst", if_inst,             mem_word(e.pc));
                chk("mon_pred", {31'd0, pred_taken}, {31'd0, e.pred});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        bp;
        logic [31:0] br_next;
`ifdef FETCH_STATIC_BP_EN
        bp      = 1'b1;
        br_next = 32'h4000_000C;
`else
        bp      = 1'b0;
        br_next = 32'h4000_0014;
`endif
        rst_n       = 1'b0;
        id_stall    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");

        // IDLE cycle after release
        rst_n = 1'b1;
        #2;
        chk("idle_en",    {31'd0, imem_en},  32'd1);
        chk("idle_addr",  imem_addr,         RST_PC);
        chk("idle_valid", {31'd0, if_valid}, 32'd0);
        push(RST_PC, 1'b0);

        tick(); #2;
        chk("c1_valid", {31'd0, if_valid}, 32'd1);
        chk("c1_pc",    if_pc,             RST_PC);
        chk("c1_addr",  imem_addr,         32'h4000_0004);
        push(32'h4000_0004, 1'b0);

        // three stalled cycles on 0x00500093
        tick();
        id_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            #2;
            chk("stall_en",    {31'd0, imem_en},    32'd0);
            chk("stall_valid", {31'd0, if_valid},   32'd1);
            chk("stall_pc",    if_pc,               32'h4000_0004);
            chk("stall_inst",  if_inst,             32'h0050_0093);
            chk("stall_pred",  {31'd0, pred_taken}, 32'd0);
        end

        tick();
        id_stall = 1'b0;
        #2;
        chk("release_en",   {31'd0, imem_en}, 32'd1);
        chk("release_addr", imem_addr,        32'h4000_0008);
        push(32'h4000_0008, 1'b0);

        tick(); #2;
        chk("seq_addr_c", imem_addr, 32'h4000_000C);
        push(32'h4000_000C, 1'b0);

        tick(); #2;
        chk("seq_addr_10", imem_addr, 32'h4000_0010);
        push(32'h4000_0010, bp);

        // backward branch at 0x4000_0010
        tick(); #2;
        chk("br_inst", if_inst,             32'hFE00_0EE3);
        chk("br_pred", {31'd0, pred_taken}, {31'd0, bp});
        chk("br_addr", imem_addr,           br_next);
        push(br_next, 1'b0);

        tick();
        id_stall = 1'b1;
        #2;
        chk("pre_redir_pc", if_pc, br_next);

        // redirect while stalled in HOLD
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h4000_0103;
        #2;
        chk("redir_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_en",    {31'd0, imem_en},  32'd1);
        chk("redir_addr",  imem_addr,         32'h4000_0100);
        exp_q.delete();
        push(32'h4000_0100, 1'b0);

        tick();
        redirect = 1'b0;
        id_stall = 1'b0;
        #2;
        chk("tgt_valid", {31'd0, if_valid}, 32'd1);
        chk("tgt_pc",    if_pc,             32'h4000_0100);
        chk("tgt_addr",  imem_addr,         32'h4000_0104);
        push(32'h4000_0104, 1'b0);

        // wrap from the top of the address space
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #2;
        chk("wrap_redir_addr", imem_addr, 32'hFFFF_FFFC);
        exp_q.delete();
        push(32'hFFFF_FFFC, 1'b0);

        tick();
        redirect = 1'b0;
        #2;
        chk("wrap_pc",   if_pc,     32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        push(32'h0000_0000, 1'b0);

        tick(); #2;
        chk("wrap2_pc",   if_pc,     32'h0000_0000);
        chk("wrap2_addr", imem_addr, 32'h0000_0004);
        push(32'h0000_0004, 1'b0);

        // reset in the middle of HOLD
        tick();
        id_stall = 1'b1;
        #2;
        chk("hold_pc", if_pc, 32'h0000_0004);
        tick(); #2;
        chk("hold_en", {31'd0, imem_en}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        exp_q.delete();

        tick();
        rst_n    = 1'b1;
        id_stall = 1'b0;
        #2;
        chk("rst2_en",   {31'd0, imem_en}, 32'd1);
        chk("rst2_addr", imem_addr,        RST_PC);
        push(RST_PC, 1'b0);

        tick(); #2;
        chk("rst2_pc",   if_pc,     RST_PC);
        chk("rst2_addr", imem_addr, 32'h4000_0004);
        push(32'h4000_0004, 1'b0);

        tick(); #2;
        chk("rst3_pc",   if_pc,     32'h4000_0004);
        chk("rst3_addr", imem_addr, 32'h4000_0008);
        push(32'h4000_0008, 1'b0);

        tick();
        id_stall = 1'b1;
        tick(); #2;
        chk("accept_count", accepts, 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
